// File: rtl/booth_mul_arbiter.sv
// Two-port round-robin front end and step sequencer for the 16x16 Booth multiplier datapath.
// Owns Er/Em/Busy, latches the granted operands and returns the product as a one-cycle pulse.
module booth_mul_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic        req1_valid,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp_result,
   output logic [15:0] mul_r1,
   output logic [15:0] mul_r2,
   output logic        mul_er,
   output logic        mul_em,
   output logic        mul_busy,
   input  logic [31:0] mul_z
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t      state_q;
   logic        ptr_q;
   logic        owner_q;
   logic [3:0]  cnt_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [31:0] res_q;
   logic        er_q;
   logic        em_q;
   logic        busy_q;
   logic        rsp0_q;
   logic        rsp1_q;

   logic        gnt_vld_d;
   logic        gnt_id_d;
   logic        hs_d;

   // With both ports pending the port that was not granted last wins.
   always_comb begin
      gnt_vld_d = req0_valid | req1_valid;
      gnt_id_d  = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_id_d = ~ptr_q;
      end else begin
         gnt_id_d = ~req0_valid;
      end
      hs_d = gnt_vld_d && (state_q == S_IDLE) && !reset;
   end

   assign req0_ready = hs_d && !gnt_id_d;
   assign req1_ready = hs_d &&  gnt_id_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b1;
         owner_q <= 1'b0;
         cnt_q   <= 4'd0;
         a_q     <= 16'd0;
         b_q     <= 16'd0;
         res_q   <= 32'd0;
         er_q    <= 1'b0;
         em_q    <= 1'b0;
         busy_q  <= 1'b1;
         rsp0_q  <= 1'b0;
         rsp1_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hs_d) begin
                  a_q     <= gnt_id_d ? req1_a : req0_a;
                  b_q     <= gnt_id_d ? req1_b : req0_b;
                  owner_q <= gnt_id_d;
                  ptr_q   <= gnt_id_d;
                  er_q    <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               er_q    <= 1'b0;
               em_q    <= 1'b1;
               cnt_q   <= 4'd0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  em_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_CAPTURE;
               end
            end
            // The datapath clears on this edge (Er=Em=0), so Z must be taken now.
            S_CAPTURE: begin
               res_q   <= mul_z;
               busy_q  <= 1'b1;
               rsp0_q  <= ~owner_q;
               rsp1_q  <= owner_q;
               state_q <= S_DONE;
            end
            S_DONE: begin
               rsp0_q  <= 1'b0;
               rsp1_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rsp0_valid = rsp0_q;
   assign rsp1_valid = rsp1_q;
   assign rsp_result = res_q;
   assign mul_r1     = a_q;
   assign mul_r2     = b_q;
   assign mul_er     = er_q;
   assign mul_em     = em_q;
   assign mul_busy   = busy_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: radix-2 Booth datapath stand-in, transaction-level reference model
// checked every cycle, and directed scenarios with literal expected results.
module tb_booth_mul_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [31:0] rsp_result;
   logic [15:0] mul_r1, mul_r2;
   logic        mul_er, mul_em, mul_busy;
   logic [31:0] mul_z;

   booth_mul_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
      .mul_r1(mul_r1), .mul_r2(mul_r2), .mul_er(mul_er), .mul_em(mul_em),
      .mul_busy(mul_busy), .mul_z(mul_z)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
   endtask

   task automatic timeout_fail(input string nm);
      n_chk++;
      $display("FAIL %s cycle %0d: timed out waiting for DUT", nm, cyc);
   endtask

   // Booth datapath stand-in: load on Er, one step per Em, clear when both low.
   logic signed [16:0] dp_acc = '0;
   logic signed [16:0] dp_s;
   logic [15:0]        dp_q = '0, dp_m = '0;
   logic               dp_q1 = 1'b0;

   always_comb begin
      dp_s = dp_acc;
      case ({dp_q[0], dp_q1})
         2'b01:   dp_s = dp_acc + $signed({dp_m[15], dp_m});
         2'b10:   dp_s = dp_acc - $signed({dp_m[15], dp_m});
         default: dp_s = dp_acc;
      endcase
   end

   always @(posedge clk) begin
      if (mul_er) begin
         dp_acc <= '0; dp_q <= mul_r2; dp_q1 <= 1'b0; dp_m <= mul_r1;
      end else if (mul_em) begin
         dp_acc <= {dp_s[16], dp_s[16:1]};
         dp_q   <= {dp_s[0], dp_q[15:1]};
         dp_q1  <= dp_q[0];
      end else begin
         dp_acc <= '0; dp_q <= '0; dp_q1 <= 1'b0;
      end
   end

   assign mul_z = mul_busy ? 32'd0 : {dp_acc[15:0], dp_q};

   // Transaction-level reference: one job in flight, timed relative to its handshake cycle.
   bit          mon_en = 1'b0;
   int          t_hs = -1;
   logic        m_ptr = 1'b1, m_owner = 1'b0;
   logic [15:0] m_a = '0, m_b = '0;
   logic [31:0] m_prod = '0, m_res = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         int   rel;
         int   sa, sb;
         logic e0, e1, g;
         rel = (t_hs >= 0) ? (cyc - t_hs) : 1000;
         e0 = 1'b0; e1 = 1'b0; g = 1'b0;
         if (!reset && rel >= 20 && (req0_valid || req1_valid)) begin
            if (req0_valid && req1_valid) g = !m_ptr;
            else g = req1_valid;
            e0 = !g; e1 = g;
         end
         if (rel == 19) m_res = m_prod;
         chk("req0_ready", req0_ready, e0);
         chk("req1_ready", req1_ready, e1);
         chk("mul_er", mul_er, rel == 1);
         chk("mul_em", mul_em, rel >= 2 && rel <= 17);
         chk("mul_busy", mul_busy, rel != 18);
         chk("rsp0_valid", rsp0_valid, rel == 19 && !m_owner);
         chk("rsp1_valid", rsp1_valid, rel == 19 && m_owner);
         chk("rsp_result", rsp_result, m_res);
         chk("mul_r1", mul_r1, m_a);
         chk("mul_r2", mul_r2, m_b);
         chk("er_em_excl", mul_er & mul_em, 0);
         chk("ready_excl", req0_ready & req1_ready, 0);
         chk("rsp_excl", rsp0_valid & rsp1_valid, 0);
         if (reset) begin
            t_hs = -1; m_ptr = 1'b1; m_a = '0; m_b = '0; m_res = '0;
         end else if (e0 || e1) begin
            t_hs = cyc; m_ptr = g; m_owner = g;
            m_a = g ? req1_a : req0_a;
            m_b = g ? req1_b : req0_b;
            sa = $signed(m_a);
            sb = $signed(m_b);
            m_prod = sa * sb;
         end
      end
   end

   int          g_ord[8], g_hs[8], g_rp[8], g_rc[8];
   logic [31:0] g_res[8];
   int          g_em, g_er;

   // Hold the enabled ports valid until n handshakes have happened, then collect n responses.
   task automatic run_req(input int n, input bit en0, input bit en1,
                          input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1);
      int ng, nr;
      ng = 0; nr = 0; g_em = 0; g_er = 0;
      @(posedge clk); #1;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      req0_valid = en0; req1_valid = en1;
      for (int k = 0; k < 20 * n + 40 && nr < n; k++) begin
         @(negedge clk);
         g_em += int'(mul_em);
         g_er += int'(mul_er);
         if (rsp0_valid || rsp1_valid) begin
            g_res[nr] = rsp_result; g_rp[nr] = int'(rsp1_valid); g_rc[nr] = cyc; nr++;
         end
         if (ng < n && (req0_ready || req1_ready)) begin
            g_ord[ng] = int'(req1_ready); g_hs[ng] = cyc; ng++;
            if (ng == n) begin
               @(posedge clk); #1;
               req0_valid = 1'b0; req1_valid = 1'b0;
            end
         end
      end
      if (nr < n) timeout_fail("run_req responses");
   endtask

   task automatic wait_ready(input bit port, output int c);
      c = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (port ? req1_ready : req0_ready) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) timeout_fail("wait_ready");
   endtask

   initial begin
      int hs0, hs1, ecount, pulses;

      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
      req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd5;
      @(negedge clk);
      chk("reset_ready0", req0_ready, 0);
      chk("reset_busy", mul_busy, 1);
      chk("reset_result", rsp_result, 32'h0);
      chk("reset_r1", mul_r1, 16'h0);
      @(posedge clk); #1 reset = 1'b0; req0_valid = 1'b0;

      // Single request on port 0.
      run_req(1, 1'b1, 1'b0, 16'd3, 16'd5, 16'd0, 16'd0);
      chk("single_port", g_ord[0], 0);
      chk("single_rsp_port", g_rp[0], 0);
      chk("single_result", g_res[0], 32'h0000000F);
      chk("single_latency", g_rc[0] - g_hs[0], 19);
      chk("single_em_cycles", g_em, 16);
      chk("single_er_cycles", g_er, 1);

      // Negative multiplier on port 1.
      run_req(1, 1'b0, 1'b1, 16'd0, 16'd0, 16'd7, 16'hFFFE);
      chk("signed_rsp_port", g_rp[0], 1);
      chk("signed_result", g_res[0], 32'hFFFFFFF2);

      // Both ports valid straight after reset.
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      run_req(2, 1'b1, 1'b1, 16'd2, 16'd4, 16'd6, 16'd3);
      chk("sim_first_port", g_ord[0], 0);
      chk("sim_second_port", g_ord[1], 1);
      chk("sim_hs_gap", g_hs[1] - g_hs[0], 20);
      chk("sim_result0", g_res[0], 32'h00000008);
      chk("sim_result1", g_res[1], 32'h00000012);

      // Fairness over four held-valid transactions.
      run_req(4, 1'b1, 1'b1, 16'd2, 16'd4, 16'd6, 16'd3);
      for (int i = 0; i < 4; i++) begin
         chk("fair_order", g_ord[i], i % 2);
         chk("fair_result", g_res[i], (i % 2) ? 32'h00000012 : 32'h00000008);
      end
      chk("fair_em_cycles", g_em, 64);

      // Port 1 raised while port 0 is running waits for the next IDLE.
      @(posedge clk); #1 req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd5;
      wait_ready(1'b0, hs0);
      @(posedge clk); #1 req0_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd4;
      wait_ready(1'b1, hs1);
      @(posedge clk); #1 req1_valid = 1'b0;
      chk("late_req1_gap", hs1 - hs0, 20);
      repeat (22) @(posedge clk);

      // Reset during the 8th Booth step.
      #1 req0_valid = 1'b1; req0_a = 16'd9; req0_b = 16'd9;
      wait_ready(1'b0, hs0);
      @(posedge clk); #1 req0_valid = 1'b0;
      ecount = 0;
      for (int k = 0; k < 30 && ecount < 7; k++) begin
         @(negedge clk);
         ecount += int'(mul_em);
      end
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_run_em8", mul_em, 1);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_run_em", mul_em, 0);
      chk("rst_run_er", mul_er, 0);
      chk("rst_run_busy", mul_busy, 1);
      pulses = 0;
      for (int k = 0; k < 25; k++) begin
         pulses += int'(rsp0_valid | rsp1_valid);
         @(negedge clk);
      end
      chk("rst_run_no_rsp", pulses, 0);
      run_req(1, 1'b1, 1'b0, 16'd1, 16'd1, 16'd0, 16'd0);
      chk("rst_run_fresh", g_res[0], 32'h00000001);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle %0d: simulation did not finish", cyc);
      $fatal(1);
   end

endmodule
